// File: rtl/sr_ctrl_pkg.sv
// Shared constants for the SR latch sequencer: FSM state codes,
// default parameters and op encoding.
package sr_ctrl_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int N_LATCH_DEF   = 8;
    localparam int PULSE_CYC_DEF = 2;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_PULSE = 3'd1;
    localparam state_t ST_GAP   = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_ACK   = 3'd4;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sr_latch_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the
// pointer wins, wrapping around.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    id_o,
    output logic             valid_o
);

    always_comb begin
        int j;
        j       = 0;
        gnt_o   = '0;
        id_o    = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!valid_o && req_i[j[IW-1:0]]) begin
                valid_o           = 1'b1;
                id_o              = j[IW-1:0];
                gnt_o[j[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer driving clean S/R pulses into a shared latch bank.
// Optional readback check enabled by defining SR_READBACK_CHECK_EN.
module sr_latch_sequencer
    import sr_ctrl_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int N_LATCH   = N_LATCH_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [N_REQ-1:0]                   i_req,
    input  logic [N_REQ-1:0]                   i_set,
    input  logic [N_REQ*$clog2(N_LATCH)-1:0]   i_idx,
    output logic [N_REQ-1:0]                   o_ack,
    output logic [N_LATCH-1:0]                 o_s,
    output logic [N_LATCH-1:0]                 o_r,
    output logic                               o_busy,
    input  logic [N_LATCH-1:0]                 i_q,
    output logic                               o_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int LW = $clog2(N_LATCH);
    localparam int CW = clog2_min1(PULSE_CYC);

    if (PULSE_CYC < 1) begin : g_bad_pulse
        $error("PULSE_CYC must be at least 1");
    end
    if (N_REQ < 2 || N_LATCH < 2) begin : g_bad_size
        $error("N_REQ and N_LATCH must be at least 2");
    end

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        win_q, win_d;
    logic                 op_q, op_d;
    logic [LW-1:0]        idx_q, idx_d;
    logic [N_LATCH-1:0]   s_q, s_d, r_q, r_d;
    logic [N_REQ-1:0]     ack_q, ack_d;

    logic [N_REQ-1:0]     arb_gnt_unused;
    logic [IW-1:0]        arb_id;
    logic                 arb_valid;
    logic [LW-1:0]        sel_idx;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt_unused),
        .id_o    (arb_id),
        .valid_o (arb_valid)
    );

    assign sel_idx = i_idx[int'(arb_id) * LW +: LW];

`ifdef SR_READBACK_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        idx_d   = idx_q;
        s_d     = s_q;
        r_d     = r_q;
        ack_d   = '0;
`ifdef SR_READBACK_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    win_d   = arb_id;
                    op_d    = i_set[arb_id];
                    idx_d   = sel_idx;
                    cnt_d   = CW'(PULSE_CYC - 1);
                    state_d = ST_PULSE;
                    if (i_set[arb_id] == OP_SET) s_d[sel_idx] = 1'b1;
                    else                         r_d[sel_idx] = 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    s_d     = '0;
                    r_d     = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
`ifdef SR_READBACK_CHECK_EN
                state_d = ST_CHECK;
`else
                state_d       = ST_ACK;
                ack_d[win_q]  = 1'b1;
`endif
            end
`ifdef SR_READBACK_CHECK_EN
            ST_CHECK: begin
                if (i_q[idx_q] != op_q) err_d = 1'b1;
                state_d      = ST_ACK;
                ack_d[win_q] = 1'b1;
            end
`endif
            ST_ACK: begin
                state_d = ST_IDLE;
                ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                r_d     = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= OP_RESET;
            idx_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            r_q     <= r_d;
            ack_q   <= ack_d;
        end
    end

`ifdef SR_READBACK_CHECK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
    assign o_err = err_q;
`else
    // Readback path is absent; keep its inputs visibly consumed.
    logic chk_unused;
    assign chk_unused = ^{i_q, idx_q, op_q};
    assign o_err      = 1'b0;
`endif

    assign o_s    = s_q;
    assign o_r    = r_q;
    assign o_ack  = ack_q;
    assign o_busy = (state_q != ST_IDLE);

endmodule
